// File: rtl/pipelined_segment_adder.sv
// pipelined_segment_adder
//   Add/subtract unit whose carry chain is cut into SEG_WIDTH-bit segments,
//   one pipeline stage per segment. Total depth is NSEG+1 register stages
//   (operand capture plus one stage per segment). A valid/ready handshake
//   stalls the whole pipe at once.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand beat handshake (in_ready = !stall)
//   a, b [WIDTH]        : unsigned operands
//   cin                 : carry-in (add) / borrow-in (sub)
//   sub                 : 1 = a - b - cin, 0 = a + b + cin (per beat)
//   out_valid/out_ready : result handshake
//   sum [WIDTH+1]       : registered result; sum[WIDTH] is carry or borrow
module pipelined_segment_adder #(
  parameter int WIDTH     = 66,
  parameter int SEG_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
);

  localparam int NSEG = (WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;
  // Operands are zero-padded to a whole number of segments plus one bit.
  // The carry out of the real top bit then lands at bit WIDTH in both the
  // padded case (inside the last segment slice) and the exact-fit case
  // (the extra top bit), so the final carry is always r_s[NSEG][WIDTH].
  localparam int PW   = NSEG * SEG_WIDTH + 1;

  logic                           w_stall;
  logic [NSEG-1:0][PW-1:0]        r_a, r_b;    // operands still to be added
  logic [NSEG-1:0]                r_c;         // carry into the next segment
  logic [NSEG:0][PW-1:0]          r_s;         // partial result; r_s[0] is always 0
  logic [NSEG:0]                  r_sub;
  logic [NSEG:0]                  r_vld_pipe;
  logic [NSEG:1][SEG_WIDTH:0]     w_seg;
  logic [NSEG:1][PW-1:0]          w_nxt;

  assign w_stall   = out_valid && !out_ready;
  assign in_ready  = !w_stall;
  assign out_valid = r_vld_pipe[NSEG];
  // Subtract runs as a + ~b + ~cin, so the top bit is the inverted carry.
  assign sum       = {r_s[NSEG][WIDTH] ^ r_sub[NSEG], r_s[NSEG][WIDTH-1:0]};

  // Stage k adds segment k-1 and merges it into the de-skewed result.
  always_comb begin
    w_seg = '0;
    w_nxt = '0;
    for (int k = 1; k <= NSEG; k++) begin
      w_seg[k] = {1'b0, r_a[k-1][(k-1)*SEG_WIDTH +: SEG_WIDTH]}
               + {1'b0, r_b[k-1][(k-1)*SEG_WIDTH +: SEG_WIDTH]}
               + {{SEG_WIDTH{1'b0}}, r_c[k-1]};
      w_nxt[k] = r_s[k-1];
      w_nxt[k][(k-1)*SEG_WIDTH +: SEG_WIDTH] = w_seg[k][SEG_WIDTH-1:0];
      if (k == NSEG) w_nxt[k][PW-1] = w_seg[k][SEG_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_c        <= '0;
      r_s        <= '0;
      r_sub      <= '0;
      r_vld_pipe <= '0;
    end else if (!w_stall) begin
      // Capture runs every unstalled cycle; in_valid=0 simply enters a bubble.
      r_vld_pipe <= {r_vld_pipe[NSEG-1:0], in_valid};
      r_sub      <= {r_sub[NSEG-1:0], sub};
      r_a[0]     <= {{(PW-WIDTH){1'b0}}, a};
      r_b[0]     <= {{(PW-WIDTH){1'b0}}, (sub ? ~b : b)};
      r_c[0]     <= cin ^ sub;
      for (int k = 1; k < NSEG; k++) begin
        r_a[k] <= r_a[k-1];
        r_b[k] <= r_b[k-1];
        r_c[k] <= w_seg[k][SEG_WIDTH];
      end
      for (int k = 1; k <= NSEG; k++) r_s[k] <= w_nxt[k];
    end
  end

endmodule
